// File: rtl/sd_spi_master.sv
// SPI mode-0 bit engine for the SD controller: sends a 48-bit command, polls MISO
// for the response start bit, captures RESP_BYTES response bytes into a 48-bit
// word and closes with a one-cycle done pulse.
module sd_spi_master #(
    parameter int HALF_BASE  = 1,
    parameter int NCR_MAX    = 8,
    parameter int RESP_BYTES = 6
) (
    input  logic        control_clk_i,
    input  logic        control_rst_i,
    input  logic        spi_rst_ni,
    input  logic        spi_start_i,
    input  logic        spi_fbo_i,
    input  logic [1:0]  clock_divider_i,
    input  logic [47:0] instruction_sd_i,
    input  logic        spi_miso_i,
    output logic        spi_SCK_o,
    output logic        spi_mosi_o,
    output logic        spi_cs_n_o,
    output logic [47:0] spi_data_o,
    output logic        spi_done_o,
    output logic        spi_busy_o,
    output logic        spi_timeout_o
);

    localparam int          RESP_BITS = RESP_BYTES * 8;
    // last bit index of the RESP phase (byte 0 is already taken in POLL)
    localparam logic [5:0]  RESP_LAST = 6'(RESP_BITS - 9);
    localparam logic [7:0]  NCR_LAST  = 8'(NCR_MAX - 1);
    localparam logic [47:0] ONES      = '1;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_POLL, S_RESP, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        cs_n_q, cs_n_d;
    logic [47:0] data_q, data_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        timeout_q, timeout_d;
    logic [47:0] frame_q, frame_d;
    logic        fbo_q, fbo_d;
    logic [1:0]  div_q, div_d;
    logic        dummy_q, dummy_d;
    logic [31:0] hcnt_q, hcnt_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  ff_cnt_q, ff_cnt_d;
    logic [47:0] sh_q, sh_d;

    logic [31:0] h_lim;
    logic        tick, rise, fall;
    logic [47:0] resp_aligned;

    // Next-state logic: SCK generation, TX shifting, RX polling and capture.
    always_comb begin
        state_d   = state_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        data_d    = data_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        timeout_d = timeout_q;
        frame_d   = frame_q;
        fbo_d     = fbo_q;
        div_d     = div_q;
        dummy_d   = dummy_q;
        hcnt_d    = hcnt_q;
        bit_cnt_d = bit_cnt_q;
        ff_cnt_d  = ff_cnt_q;
        sh_d      = sh_q;

        h_lim = (32'(HALF_BASE) << div_q) - 32'd1;
        tick  = (hcnt_q == h_lim);
        rise  = tick & ~sck_q;
        fall  = tick & sck_q;
        // last RESP_BITS received bits, left-aligned, padded with 1s
        resp_aligned = (sh_q << (48 - RESP_BITS)) | ~(ONES << (48 - RESP_BITS));

        case (state_q)
            S_IDLE: begin
                if (spi_start_i) begin
                    frame_d   = instruction_sd_i;
                    fbo_d     = spi_fbo_i;
                    div_d     = clock_divider_i;
                    dummy_d   = (instruction_sd_i[47:46] == 2'b11);
                    cs_n_d    = (instruction_sd_i[47:46] == 2'b11);
                    mosi_d    = (instruction_sd_i[47:46] == 2'b11) ? 1'b1 :
                                (spi_fbo_i ? instruction_sd_i[47] : instruction_sd_i[0]);
                    busy_d    = 1'b1;
                    sck_d     = 1'b0;
                    hcnt_d    = '0;
                    bit_cnt_d = '0;
                    ff_cnt_d  = '0;
                    sh_d      = '1;
                    state_d   = S_CMD;
                end
            end
            S_CMD, S_POLL, S_RESP: begin
                if (tick) begin
                    hcnt_d = '0;
                    sck_d  = ~sck_q;
                end else begin
                    hcnt_d = hcnt_q + 32'd1;
                end
                if (rise && state_q != S_CMD) sh_d = {sh_q[46:0], spi_miso_i};
                if (fall) begin
                    if (state_q == S_CMD) begin
                        if (bit_cnt_q == 6'd47) begin
                            bit_cnt_d = '0;
                            mosi_d    = 1'b1;
                            if (dummy_q) begin
                                timeout_d = 1'b0;
                                state_d   = S_DONE;
                            end else begin
                                state_d = S_POLL;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 6'd1;
                            frame_d   = fbo_q ? (frame_q << 1) : (frame_q >> 1);
                            mosi_d    = dummy_q ? 1'b1 : (fbo_q ? frame_q[46] : frame_q[1]);
                        end
                    end else if (state_q == S_POLL) begin
                        if (bit_cnt_q == 6'd7) begin
                            bit_cnt_d = '0;
                            if (!sh_q[7]) begin
                                // first bit of this byte was 0: it is the R1 byte
                                if (RESP_BYTES == 1) begin
                                    data_d    = resp_aligned;
                                    timeout_d = 1'b0;
                                    state_d   = S_DONE;
                                end else begin
                                    state_d = S_RESP;
                                end
                            end else if (ff_cnt_q == NCR_LAST) begin
                                data_d    = ONES;
                                timeout_d = 1'b1;
                                state_d   = S_DONE;
                            end else begin
                                ff_cnt_d = ff_cnt_q + 8'd1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 6'd1;
                        end
                    end else begin
                        if (bit_cnt_q == RESP_LAST) begin
                            data_d    = resp_aligned;
                            timeout_d = 1'b0;
                            state_d   = S_DONE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 6'd1;
                        end
                    end
                end
            end
            S_DONE: begin
                sck_d   = 1'b0;
                mosi_d  = 1'b1;
                cs_n_d  = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // controller soft reset aborts everything without a done pulse
        if (!spi_rst_ni) begin
            state_d   = S_IDLE;
            sck_d     = 1'b0;
            mosi_d    = 1'b1;
            cs_n_d    = 1'b1;
            data_d    = '0;
            done_d    = 1'b0;
            busy_d    = 1'b0;
            timeout_d = 1'b0;
            hcnt_d    = '0;
            bit_cnt_d = '0;
            ff_cnt_d  = '0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge control_clk_i or posedge control_rst_i) begin
        if (control_rst_i) begin
            state_q   <= S_IDLE;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b1;
            cs_n_q    <= 1'b1;
            data_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            frame_q   <= '0;
            fbo_q     <= 1'b0;
            div_q     <= '0;
            dummy_q   <= 1'b0;
            hcnt_q    <= '0;
            bit_cnt_q <= '0;
            ff_cnt_q  <= '0;
            sh_q      <= '1;
        end else begin
            state_q   <= state_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            data_q    <= data_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            frame_q   <= frame_d;
            fbo_q     <= fbo_d;
            div_q     <= div_d;
            dummy_q   <= dummy_d;
            hcnt_q    <= hcnt_d;
            bit_cnt_q <= bit_cnt_d;
            ff_cnt_q  <= ff_cnt_d;
            sh_q      <= sh_d;
        end
    end

    assign spi_SCK_o     = sck_q;
    assign spi_mosi_o    = mosi_q;
    assign spi_cs_n_o    = cs_n_q;
    assign spi_data_o    = data_q;
    assign spi_done_o    = done_q;
    assign spi_busy_o    = busy_q;
    assign spi_timeout_o = timeout_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// Bench for sd_spi_master: card model on MISO, MOSI/SCK monitors and a
// frame-level reference model of the expected response word and SCK count.
module tb_sd_spi_master;

    localparam int HB  = 1;
    localparam int NCR = 8;
    localparam int RB  = 6;

    logic        control_clk_i = 1'b0;
    logic        control_rst_i = 1'b1;
    logic        spi_rst_ni = 1'b1;
    logic        spi_start_i = 1'b0;
    logic        spi_fbo_i = 1'b1;
    logic [1:0]  clock_divider_i = 2'd0;
    logic [47:0] instruction_sd_i = '0;
    logic        spi_miso_i;
    logic        spi_SCK_o, spi_mosi_o, spi_cs_n_o, spi_done_o, spi_busy_o, spi_timeout_o;
    logic [47:0] spi_data_o;

    sd_spi_master #(.HALF_BASE(HB), .NCR_MAX(NCR), .RESP_BYTES(RB)) dut (
        .control_clk_i(control_clk_i), .control_rst_i(control_rst_i), .spi_rst_ni(spi_rst_ni),
        .spi_start_i(spi_start_i), .spi_fbo_i(spi_fbo_i), .clock_divider_i(clock_divider_i),
        .instruction_sd_i(instruction_sd_i), .spi_miso_i(spi_miso_i), .spi_SCK_o(spi_SCK_o),
        .spi_mosi_o(spi_mosi_o), .spi_cs_n_o(spi_cs_n_o), .spi_data_o(spi_data_o),
        .spi_done_o(spi_done_o), .spi_busy_o(spi_busy_o), .spi_timeout_o(spi_timeout_o));

    always #5 control_clk_i = ~control_clk_i;

    int total = 0;
    int bad = 0;

    // card response stream, sent after the 48 command clocks; 8'hFF beyond the end
    logic [7:0] card_q[$];
    logic       miso_r = 1'b1;
    int         sck_cnt = 0, sck_base = 0, done_cnt = 0, cs_low_cnt = 0, per_err = 0, exp_h = 1;
    logic       mosi_hist [0:1023];
    assign spi_miso_i = miso_r;

    function automatic logic [7:0] byte_at(input int i);
        if (i < card_q.size()) return card_q[i];
        return 8'hFF;
    endfunction

    function automatic logic card_bit(input int k);
        logic [7:0] b;
        if (k < 48) return 1'b1;
        b = byte_at((k - 48) / 8);
        return b[7 - ((k - 48) % 8)];
    endfunction

    // record MOSI at each SCK rise and present the card's next bit
    always @(posedge spi_SCK_o) begin
        mosi_hist[sck_cnt % 1024] = spi_mosi_o;
        sck_cnt++;
        miso_r = card_bit(sck_cnt - sck_base);
    end

    logic sck_prev = 1'b0, busy_prev = 1'b0;
    int   hi_run = 0, lo_run = 0;
    // count done pulses, CS activity and check every SCK phase lasts exp_h clocks
    always @(negedge control_clk_i) begin
        if (spi_done_o) done_cnt++;
        if (!spi_cs_n_o) cs_low_cnt++;
        if (spi_busy_o && !busy_prev) lo_run = 0;
        if (spi_SCK_o) begin
            if (!sck_prev) begin
                if (spi_busy_o && lo_run != exp_h) per_err++;
                hi_run = 0;
            end
            hi_run++;
        end else begin
            if (sck_prev) begin
                if (hi_run != exp_h) per_err++;
                lo_run = 0;
            end
            lo_run++;
        end
        sck_prev  = spi_SCK_o;
        busy_prev = spi_busy_o;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // frame-level model: response word, timeout flag and number of SCK periods
    function automatic void model(input logic [47:0] instr, output logic [47:0] d,
                                  output logic to, output int ns);
        int j;
        logic [7:0] b;
        d = '1; to = 1'b0; ns = 48; j = -1;
        if (instr[47:46] == 2'b11) return;
        for (int i = 0; i < NCR; i++) begin
            b = byte_at(i);
            if (j < 0 && !b[7]) j = i;
        end
        if (j < 0) begin
            to = 1'b1; ns = 48 + 8 * NCR;
            return;
        end
        for (int i = 0; i < RB; i++) d[47 - 8 * i -: 8] = byte_at(j + i);
        ns = 48 + 8 * (j + RB);
    endfunction

    task automatic kick(input logic [47:0] instr, input logic fbo, input logic [1:0] div);
        exp_h = HB << div;
        @(posedge control_clk_i); #1;
        sck_base = sck_cnt;
        instruction_sd_i = instr; spi_fbo_i = fbo; clock_divider_i = div; spi_start_i = 1'b1;
        @(posedge control_clk_i); #1;
        spi_start_i = 1'b0;
    endtask

    task automatic run(input string tag, input logic [47:0] instr, input logic fbo,
                       input logic [1:0] div, input bit poke);
        logic [47:0] ed;
        logic        eto, dummy, got, eb;
        int          ens, s0, d0, c0, p0, mm;
        model(instr, ed, eto, ens);
        dummy = (instr[47:46] == 2'b11);
        d0 = done_cnt; c0 = cs_low_cnt; p0 = per_err;
        kick(instr, fbo, div);
        s0 = sck_base;
        chk({tag, "_start"}, {62'd0, spi_busy_o, spi_cs_n_o}, {62'd0, 1'b1, dummy});
        if (poke) begin
            repeat (20) @(posedge control_clk_i);
            #1 instruction_sd_i = ~instr; spi_fbo_i = ~fbo; clock_divider_i = ~div; spi_start_i = 1'b1;
            @(posedge control_clk_i); #1 spi_start_i = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge control_clk_i);
            if (spi_done_o) begin got = 1'b1; break; end
        end
        chk({tag, "_done_seen"}, {63'd0, got}, 64'd1);
        if (got) begin
            if (!dummy) chk({tag, "_data"}, {16'd0, spi_data_o}, {16'd0, ed});
            chk({tag, "_timeout"}, {63'd0, spi_timeout_o}, {63'd0, eto});
            chk({tag, "_idle_pins"}, {61'd0, spi_busy_o, spi_cs_n_o, spi_SCK_o}, 64'd2);
        end
        repeat (3) @(negedge control_clk_i);
        chk({tag, "_sck_count"}, 64'(sck_cnt - s0), 64'(ens));
        chk({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        mm = 0;
        for (int k = 0; k < ens; k++) begin
            eb = dummy ? 1'b1 : (k < 48 ? (fbo ? instr[47 - k] : instr[k]) : 1'b1);
            if (mosi_hist[(s0 + k) % 1024] !== eb) mm++;
        end
        chk({tag, "_mosi_bits"}, 64'(mm), 64'd0);
        chk({tag, "_sck_phase"}, 64'(per_err - p0), 64'd0);
        if (dummy) chk({tag, "_cs_high"}, 64'(cs_low_cnt - c0), 64'd0);
    endtask

    initial begin
        int d0;
        bit reached;
        logic [47:0] ri;
        repeat (3) @(posedge control_clk_i);
        #1 control_rst_i = 1'b0;
        @(negedge control_clk_i);
        chk("rst_sck", {63'd0, spi_SCK_o}, 64'd0);
        chk("rst_mosi", {63'd0, spi_mosi_o}, 64'd1);
        chk("rst_cs_n", {63'd0, spi_cs_n_o}, 64'd1);
        chk("rst_data", {16'd0, spi_data_o}, 64'd0);
        chk("rst_done", {63'd0, spi_done_o}, 64'd0);
        chk("rst_busy", {63'd0, spi_busy_o}, 64'd0);
        chk("rst_timeout", {63'd0, spi_timeout_o}, 64'd0);

        card_q = '{8'hFF, 8'hFF, 8'h01};
        run("cmd0", 48'h400000000095, 1'b1, 2'd0, 1'b0);
        card_q = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
        run("cmd8_poke", 48'h48000001AA87, 1'b1, 2'd0, 1'b1);
        card_q = '{};
        run("stuck1", 48'h7700000000FF, 1'b1, 2'd0, 1'b0);
        run("dummy", 48'hFFFFFFFFFFFF, 1'b1, 2'd0, 1'b0);
        card_q = '{8'hFF, 8'h05, 8'h12};
        run("div3_lsb", 48'h51A5C3000123, 1'b0, 2'd3, 1'b0);

        // soft reset in the middle of the command phase
        card_q = '{8'h01};
        d0 = done_cnt;
        kick(48'h400000000095, 1'b1, 2'd0);
        repeat (20) @(posedge control_clk_i);
        #1 spi_rst_ni = 1'b0;
        @(posedge control_clk_i); #1;
        chk("srst_pins", {60'd0, spi_cs_n_o, spi_SCK_o, spi_busy_o, spi_done_o}, 64'h8);
        spi_rst_ni = 1'b1;
        repeat (10) @(negedge control_clk_i);
        chk("srst_no_done", 64'(done_cnt - d0), 64'd0);

        // asynchronous reset once the response bytes are being clocked
        card_q = '{8'h01, 8'h22, 8'h33};
        d0 = done_cnt;
        kick(48'h5100000000FF, 1'b1, 2'd0);
        reached = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge control_clk_i);
            if (sck_cnt - sck_base >= 70) begin reached = 1'b1; break; end
        end
        chk("arst_reach_resp", {63'd0, reached}, 64'd1);
        #1 control_rst_i = 1'b1;
        #1;
        chk("arst_pins", {60'd0, spi_cs_n_o, spi_SCK_o, spi_busy_o, spi_done_o}, 64'h8);
        chk("arst_data", {16'd0, spi_data_o}, 64'd0);
        @(negedge control_clk_i) control_rst_i = 1'b0;
        repeat (10) @(negedge control_clk_i);
        chk("arst_no_done", 64'(done_cnt - d0), 64'd0);

        // randomized frames and card behaviour
        for (int t = 0; t < 8; t++) begin
            card_q = '{};
            for (int i = $urandom_range(0, 9); i > 0; i--) card_q.push_back(8'hFF);
            card_q.push_back(8'($urandom_range(0, 127)));
            for (int i = 0; i < 5; i++) card_q.push_back(8'($urandom));
            ri = {16'($urandom), $urandom};
            if (t % 3 != 2) ri[47:46] = 2'b01;
            run($sformatf("rnd%0d", t), ri, 1'($urandom), 2'($urandom_range(0, 2)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
